// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode constants.
// Used by the receiver and intended for the parametrised transmitter too.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } uartState_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_rx_param_if.sv
// Core-side bus of the UART receiver: held word, status flags and FSM state.
//
// Handshake: valid=1 means dataOut (and parity_err/frame_err) hold a word the
// consumer has not taken yet. The consumer takes it on any clock edge where
// valid=1 and ack=1; ack while valid=0 has no effect. dataOut and the error
// flags keep their value after the word is taken.
interface uart_rx_param_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8
);
   logic                 ack;
   logic [DATA_BITS-1:0] dataOut;
   logic                 valid;
   logic                 ready;
   logic                 new_byte_indicate;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun;
   uartState_t           state;

   modport master (
      input  ack,
      output dataOut, valid, ready, new_byte_indicate,
      output parity_err, frame_err, overrun, state
   );

   modport slave (
      output ack,
      input  dataOut, valid, ready, new_byte_indicate,
      input  parity_err, frame_err, overrun, state
   );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input; resets to 1 so an idle-high
// line does not produce a false low right after reset.
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   // Shift the async input through two flops.
   always_ff @(posedge clk) begin
      if (!rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver. Oversampled start detection, LSB-first data,
// optional parity, one or two stop bits, and a held output word with
// valid/ack handshake plus parity/framing/overrun status.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = PARITY_NONE,
   parameter int STOP_BITS  = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic boudTick,
   input  logic rx,
   uart_rx_param_if.master bus
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic          PAR_ODD   = (PARITY == PARITY_ODD);

   logic                 rxS;
   uartState_t           state, stateNext;
   logic [TW-1:0]        tickCnt, tickNext;
   logic [BW-1:0]        bitCnt, bitNext;
   logic [DATA_BITS-1:0] shiftReg, shiftNext;
   logic                 perr, perrNext;
   logic                 ferr, ferrNext;
   logic                 load;
   logic                 startOk;

   logic [DATA_BITS-1:0] dataReg;
   logic                 validReg, perrReg, ferrReg, ovrReg;

   uart_sync2 rxSync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rxS)
   );

   // FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         tickCnt  <= '0;
         bitCnt   <= '0;
         shiftReg <= '0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
      end else begin
         state    <= stateNext;
         tickCnt  <= tickNext;
         bitCnt   <= bitNext;
         shiftReg <= shiftNext;
         perr     <= perrNext;
         ferr     <= ferrNext;
      end
   end

   // Next state, counters, shifting and per-frame error capture.
   always_comb begin
      stateNext = state;
      tickNext  = tickCnt;
      bitNext   = bitCnt;
      shiftNext = shiftReg;
      perrNext  = perr;
      ferrNext  = ferr;
      load      = 1'b0;
      startOk   = 1'b0;
      case (state)
         IDLE: begin
            tickNext = '0;
            bitNext  = '0;
            if (!rxS) stateNext = START;
         end
         START: if (boudTick) begin
            if (tickCnt == TICK_MID) begin
               tickNext = '0;
               if (!rxS) begin
                  // Still low at mid start bit: a real frame.
                  stateNext = DATA;
                  startOk   = 1'b1;
                  shiftNext = '0;
                  perrNext  = 1'b0;
                  ferrNext  = 1'b0;
               end else begin
                  stateNext = IDLE;
               end
            end else begin
               tickNext = tickCnt + 1'b1;
            end
         end
         DATA: if (boudTick) begin
            if (tickCnt == TICK_LAST) begin
               tickNext  = '0;
               shiftNext = {rxS, shiftReg[DATA_BITS-1:1]};
               if (bitCnt == DATA_LAST) begin
                  bitNext   = '0;
                  stateNext = (PARITY != PARITY_NONE) ? PAR : STOP;
               end else begin
                  bitNext = bitCnt + 1'b1;
               end
            end else begin
               tickNext = tickCnt + 1'b1;
            end
         end
         PAR: if (boudTick) begin
            if (tickCnt == TICK_LAST) begin
               tickNext  = '0;
               perrNext  = rxS ^ (^shiftReg) ^ PAR_ODD;
               stateNext = STOP;
            end else begin
               tickNext = tickCnt + 1'b1;
            end
         end
         STOP: if (boudTick) begin
            if (tickCnt == TICK_LAST) begin
               tickNext = '0;
               if (!rxS) ferrNext = 1'b1;
               if (bitCnt == STOP_LAST) begin
                  // Leave mid stop bit so a back-to-back start edge is caught.
                  bitNext   = '0;
                  load      = 1'b1;
                  stateNext = IDLE;
               end else begin
                  bitNext = bitCnt + 1'b1;
               end
            end else begin
               tickNext = tickCnt + 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Output holding register with valid/ack handshake and sticky overrun.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dataReg  <= '0;
         validReg <= 1'b0;
         perrReg  <= 1'b0;
         ferrReg  <= 1'b0;
         ovrReg   <= 1'b0;
      end else if (load) begin
         dataReg  <= shiftReg;
         perrReg  <= perr;
         ferrReg  <= ferrNext;
         validReg <= 1'b1;
         // Unconsumed word overwritten; a simultaneous ack leaves overrun alone.
         if (validReg && !bus.ack) ovrReg <= 1'b1;
      end else if (validReg && bus.ack) begin
         validReg <= 1'b0;
         ovrReg   <= 1'b0;
      end
   end

   assign bus.dataOut           = dataReg;
   assign bus.valid             = validReg;
   assign bus.parity_err        = perrReg;
   assign bus.frame_err         = ferrReg;
   assign bus.overrun           = ovrReg;
   assign bus.ready             = (state == IDLE);
   assign bus.new_byte_indicate = startOk;
   assign bus.state             = state;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four configurations (8N1, 8E1, 8N2, 9N1 with a
// divided baud tick) driven from one clock, table of frames plus hand-written
// glitch, back-to-back/overrun and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_rx_param;
   import uart_pkg::*;

   typedef struct {
      int         inst;
      logic [8:0] data;
      bit         parBit;
      logic [1:0] stopPat;
      logic [8:0] expData;
      bit         expPerr;
      bit         expFerr;
   } vec_t;

   typedef struct {
      logic [8:0] data;
      logic       valid;
      logic       ready;
      logic       perr;
      logic       ferr;
      logic       ovr;
      logic [2:0] st;
   } obs_t;

   // Clock/reset block.
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tickHi = 1'b1;
   logic tickD;
   int   cyc = 0;
   int   divCnt = 0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc    <= cyc + 1;
      divCnt <= (divCnt + 1) % 4;
   end
   assign tickD = (divCnt == 0);

   logic rxA = 1'b1, rxB = 1'b1, rxC = 1'b1, rxD = 1'b1;

   // Per-instance configuration: clocks per bit, data bits, parity, stop bits.
   int cpbOf[4]   = '{16, 16, 16, 64};
   int nDataOf[4] = '{8, 8, 8, 9};
   int parOf[4]   = '{0, 1, 0, 0};
   int nStopOf[4] = '{1, 1, 2, 1};

   uart_rx_param_if #(.DATA_BITS(8)) busA ();
   uart_rx_param_if #(.DATA_BITS(8)) busB ();
   uart_rx_param_if #(.DATA_BITS(8)) busC ();
   uart_rx_param_if #(.DATA_BITS(9)) busD ();

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dutA (
      .clk(clk), .rst(rst), .boudTick(tickHi), .rx(rxA), .bus(busA));
   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) dutB (
      .clk(clk), .rst(rst), .boudTick(tickHi), .rx(rxB), .bus(busB));
   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2)) dutC (
      .clk(clk), .rst(rst), .boudTick(tickHi), .rx(rxC), .bus(busC));
   uart_rx_param #(.DATA_BITS(9), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dutD (
      .clk(clk), .rst(rst), .boudTick(tickD), .rx(rxD), .bus(busD));

   int errors = 0;
   int checks = 0;
   int nbCnt[4]    = '{0, 0, 0, 0};
   int riseCyc[4]  = '{0, 0, 0, 0};
   int startCyc[4] = '{0, 0, 0, 0};
   logic prevV[4]  = '{1'b0, 1'b0, 1'b0, 1'b0};

   function automatic obs_t getObs(input int which);
      obs_t o;
      o = '{default: '0};
      case (which)
         0: begin o.data = {1'b0, busA.dataOut}; o.valid = busA.valid; o.ready = busA.ready;
                  o.perr = busA.parity_err; o.ferr = busA.frame_err; o.ovr = busA.overrun; o.st = busA.state; end
         1: begin o.data = {1'b0, busB.dataOut}; o.valid = busB.valid; o.ready = busB.ready;
                  o.perr = busB.parity_err; o.ferr = busB.frame_err; o.ovr = busB.overrun; o.st = busB.state; end
         2: begin o.data = {1'b0, busC.dataOut}; o.valid = busC.valid; o.ready = busC.ready;
                  o.perr = busC.parity_err; o.ferr = busC.frame_err; o.ovr = busC.overrun; o.st = busC.state; end
         default: begin o.data = busD.dataOut; o.valid = busD.valid; o.ready = busD.ready;
                  o.perr = busD.parity_err; o.ferr = busD.frame_err; o.ovr = busD.overrun; o.st = busD.state; end
      endcase
      return o;
   endfunction

   function automatic logic getNb(input int which);
      case (which)
         0: return busA.new_byte_indicate;
         1: return busB.new_byte_indicate;
         2: return busC.new_byte_indicate;
         default: return busD.new_byte_indicate;
      endcase
   endfunction

   // Monitor: count start pulses and note the cycle valid rises.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         obs_t o;
         o = getObs(i);
         if (getNb(i) === 1'b1) nbCnt[i]++;
         if (o.valid === 1'b1 && !prevV[i]) riseCyc[i] = cyc;
         prevV[i] = (o.valid === 1'b1);
      end
   end

   // Scoreboard compare.
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Driver tasks.
   task automatic setRx(input int which, input logic v);
      case (which)
         0: rxA = v;
         1: rxB = v;
         2: rxC = v;
         default: rxD = v;
      endcase
   endtask

   task automatic setAck(input int which, input logic v);
      case (which)
         0: busA.ack = v;
         1: busB.ack = v;
         2: busC.ack = v;
         default: busD.ack = v;
      endcase
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic driveBit(input int which, input logic v, input int clks);
      setRx(which, v);
      idle(clks);
   endtask

   task automatic sendFrame(input int which, input logic [8:0] data, input bit parBit,
                            input logic [1:0] stopPat);
      int cpb;
      cpb = cpbOf[which];
      startCyc[which] = cyc;
      driveBit(which, 1'b0, cpb);
      for (int i = 0; i < nDataOf[which]; i++) driveBit(which, data[i], cpb);
      if (parOf[which] != 0) driveBit(which, parBit, cpb);
      for (int i = 0; i < nStopOf[which]; i++) driveBit(which, stopPat[i], cpb);
      setRx(which, 1'b1);
   endtask

   task automatic ackPulse(input int which);
      setAck(which, 1'b1);
      idle(1);
      setAck(which, 1'b0);
   endtask

   task automatic waitValid(input int which, input string name);
      int n;
      obs_t o;
      n = 0;
      o = getObs(which);
      while (o.valid !== 1'b1 && n < 200) begin
         idle(1);
         n++;
         o = getObs(which);
      end
      chk({name, " valid"}, o.valid, 1);
   endtask

   task automatic runVec(input vec_t v, input int idx);
      int nb0;
      int expLat;
      obs_t o;
      string nm;
      nm  = $sformatf("v%0d", idx);
      nb0 = nbCnt[v.inst];
      sendFrame(v.inst, v.data, v.parBit, v.stopPat);
      waitValid(v.inst, nm);
      o = getObs(v.inst);
      chk({nm, " data"}, o.data, v.expData);
      chk({nm, " parity_err"}, o.perr, v.expPerr);
      chk({nm, " frame_err"}, o.ferr, v.expFerr);
      chk({nm, " overrun"}, o.ovr, 0);
      chk({nm, " start pulses"}, nbCnt[v.inst] - nb0, 1);
      if (cpbOf[v.inst] == 16) begin
         expLat = 3 + 8 + (nDataOf[v.inst] + parOf[v.inst] + nStopOf[v.inst]) * 16;
         chk({nm, " latency"}, riseCyc[v.inst] - startCyc[v.inst], expLat);
      end
      ackPulse(v.inst);
      o = getObs(v.inst);
      chk({nm, " valid after ack"}, o.valid, 0);
      chk({nm, " data held"}, o.data, v.expData);
      idle(2 * cpbOf[v.inst]);
   endtask

   task automatic resetMidFrame(input int which, input logic [8:0] data);
      int cpb;
      cpb = cpbOf[which];
      driveBit(which, 1'b0, cpb);
      for (int i = 0; i < 3; i++) driveBit(which, data[i], cpb);
      setRx(which, data[3]);
      idle(cpb / 2);
      rst = 1'b0;
      setRx(which, 1'b1);
      idle(1);
      rst = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[9];
      vec_t v;
      obs_t o;
      int nb0;

      vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
      vecs[1] = '{0, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0};
      vecs[2] = '{1, 9'h007, 1'b0, 2'b11, 9'h007, 1'b1, 1'b0};
      vecs[3] = '{1, 9'h007, 1'b1, 2'b11, 9'h007, 1'b0, 1'b0};
      vecs[4] = '{1, 9'h0F0, 1'b0, 2'b11, 9'h0F0, 1'b0, 1'b0};
      vecs[5] = '{1, 9'h0F1, 1'b0, 2'b11, 9'h0F1, 1'b1, 1'b0};
      vecs[6] = '{2, 9'h03C, 1'b0, 2'b01, 9'h03C, 1'b0, 1'b1};
      vecs[7] = '{2, 9'h0C3, 1'b0, 2'b11, 9'h0C3, 1'b0, 1'b0};
      vecs[8] = '{3, 9'h155, 1'b0, 2'b11, 9'h155, 1'b0, 1'b0};

      busA.ack = 1'b0;
      busB.ack = 1'b0;
      busC.ack = 1'b0;
      busD.ack = 1'b0;

      // Reset state of every instance.
      rst = 1'b0;
      idle(4);
      for (int i = 0; i < 4; i++) begin
         o = getObs(i);
         chk($sformatf("rst%0d ready", i), o.ready, 1);
         chk($sformatf("rst%0d valid", i), o.valid, 0);
         chk($sformatf("rst%0d data", i), o.data, 0);
         chk($sformatf("rst%0d errs", i), {o.perr, o.ferr, o.ovr}, 0);
         chk($sformatf("rst%0d state", i), o.st, 32'(IDLE));
      end
      rst = 1'b1;
      idle(4);

      // Directed frame table.
      for (int i = 0; i < 9; i++) runVec(vecs[i], i);

      // Short low glitch on the line is rejected.
      nb0 = nbCnt[0];
      driveBit(0, 1'b0, 4);
      setRx(0, 1'b1);
      idle(40);
      o = getObs(0);
      chk("glitch start pulses", nbCnt[0] - nb0, 0);
      chk("glitch valid", o.valid, 0);
      chk("glitch ready", o.ready, 1);

      // Back-to-back frames without ack: overwrite and overrun.
      sendFrame(0, 9'h011, 1'b0, 2'b11);
      o = getObs(0);
      chk("b2b first valid", o.valid, 1);
      chk("b2b first data", o.data, 9'h011);
      chk("b2b first overrun", o.ovr, 0);
      sendFrame(0, 9'h022, 1'b0, 2'b11);
      o = getObs(0);
      chk("b2b second valid", o.valid, 1);
      chk("b2b second data", o.data, 9'h022);
      chk("b2b overrun", o.ovr, 1);
      ackPulse(0);
      o = getObs(0);
      chk("b2b ack valid", o.valid, 0);
      chk("b2b ack overrun", o.ovr, 0);
      idle(32);

      // Reset during data bit 3 with a word still held.
      sendFrame(0, 9'h066, 1'b0, 2'b11);
      o = getObs(0);
      chk("held before reset", o.valid, 1);
      resetMidFrame(0, 9'h099);
      o = getObs(0);
      chk("midrst ready", o.ready, 1);
      chk("midrst valid", o.valid, 0);
      chk("midrst data", o.data, 0);
      chk("midrst state", o.st, 32'(IDLE));
      nb0 = nbCnt[0];
      idle(48);
      o = getObs(0);
      chk("midrst no false start", nbCnt[0] - nb0, 0);
      chk("midrst still ready", o.ready, 1);
      v = '{0, 9'h05A, 1'b0, 2'b11, 9'h05A, 1'b0, 1'b0};
      runVec(v, 20);

      // Ack with nothing held changes nothing.
      ackPulse(0);
      o = getObs(0);
      chk("idle ack valid", o.valid, 0);
      chk("idle ack data", o.data, 9'h05A);

      // Same reset scenario on the 9-bit, divided-tick instance.
      resetMidFrame(3, 9'h0F0);
      o = getObs(3);
      chk("midrstD ready", o.ready, 1);
      chk("midrstD valid", o.valid, 0);
      idle(128);
      v = '{3, 9'h1FF, 1'b0, 2'b11, 9'h1FF, 1'b0, 1'b0};
      runVec(v, 21);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
